// File: rtl/serial_alu_sequencer.sv
// Purpose: bit-serial front end for the 1-bit ALU slice, LSB first, carry chained.
// Latency: accept edge T, WIDTH RUN cycles, out_valid high after edge T+WIDTH.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   in_valid/in_ready             operation handshake (in_op1, in_op2, in_mode,
//                                 in_opsel, in_cin)
//   slice_op1/op2/mode/opsel/cin  operand bit pair and controls to the slice
//   slice_result/slice_cout       combinational slice outputs
//   out_valid/out_ready           result handshake (out_result, out_cout)
//   busy                          high in RUN or DONE
module serial_alu_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_op1,
  input  logic [WIDTH-1:0] in_op2,
  input  logic             in_mode,
  input  logic [2:0]       in_opsel,
  input  logic             in_cin,
  output logic             slice_op1,
  output logic             slice_op2,
  output logic             slice_mode,
  output logic [2:0]       slice_opsel,
  output logic             slice_cin,
  input  logic             slice_result,
  input  logic             slice_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_cout,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] op1_sh;
  logic [WIDTH-1:0] op2_sh;
  logic [WIDTH-1:0] res_sh;
  logic [WIDTH-1:0] res_next;
  logic             carry;
  logic             mode_q;
  logic [2:0]       opsel_q;
  logic [CW-1:0]    cnt;

  // Result bits enter at the MSB and move right, so after WIDTH shifts
  // the first (LSB) result bit sits at bit 0. A 1-bit word has nothing to shift.
  generate
    if (WIDTH == 1) begin : g_res_w1
      assign res_next = slice_result;
    end else begin : g_res_wn
      assign res_next = {slice_result, res_sh[WIDTH-1:1]};
    end
  endgenerate

  assign in_ready = (state == ST_IDLE);
  assign busy     = (state != ST_IDLE);

  // Slice inputs are only meaningful in RUN; hold them quiet otherwise.
  always_comb begin
    slice_op1   = 1'b0;
    slice_op2   = 1'b0;
    slice_mode  = 1'b0;
    slice_opsel = 3'd0;
    slice_cin   = 1'b0;
    if (state == ST_RUN) begin
      slice_op1   = op1_sh[0];
      slice_op2   = op2_sh[0];
      slice_mode  = mode_q;
      slice_opsel = opsel_q;
      slice_cin   = carry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      op1_sh     <= '0;
      op2_sh     <= '0;
      res_sh     <= '0;
      carry      <= 1'b0;
      mode_q     <= 1'b0;
      opsel_q    <= 3'd0;
      cnt        <= '0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_cout   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            op1_sh  <= in_op1;
            op2_sh  <= in_op2;
            mode_q  <= in_mode;
            opsel_q <= in_opsel;
            carry   <= in_cin;
            cnt     <= '0;
            res_sh  <= '0;
            state   <= ST_RUN;
          end
        end
        ST_RUN: begin
          res_sh <= res_next;
          carry  <= slice_cout;
          op1_sh <= op1_sh >> 1;
          op2_sh <= op2_sh >> 1;
          if (cnt == LAST_BIT) begin
            // Final bit: publish the word straight from the shift input
            // so the last slice result is not lost a cycle.
            out_result <= res_next;
            out_cout   <= slice_cout;
            out_valid  <= 1'b1;
            state      <= ST_DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/serial_alu_sequencer.md
Name: serial_alu_sequencer

Overview:
Bit-serial front end for the team's 1-bit ALU slice. It accepts a WIDTH-bit operation over a valid/ready handshake and presents one operand bit pair per clock to the combinational slice, LSB first. It chains the slice carry between bits and reassembles the result bits into a WIDTH-bit word. The finished word is returned over a second valid/ready handshake. The block sits directly upstream of the slice, which drives its operand inputs, and directly downstream of it, which consumes its result and carry outputs.

Parameters:
WIDTH, 8, operand/result width in bits; legal range is 1 or greater.

Ports:
clk  input  1  rising-edge clock; the only clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  upstream holds a valid operation
in_ready  output  1  sequencer can accept an operation
in_op1  input  WIDTH  operand 1
in_op2  input  WIDTH  operand 2
in_mode  input  1  arithmetic/logic mode, passed through to the slice
in_opsel  input  3  operation select, passed through to the slice
in_cin  input  1  carry-in for bit 0, from the carry-select logic
slice_op1  output  1  current bit of operand 1
slice_op2  output  1  current bit of operand 2
slice_mode  output  1  latched mode
slice_opsel  output  3  latched opsel
slice_cin  output  1  carry into the current bit
slice_result  input  1  slice result bit, combinational from the slice_* outputs
slice_cout  input  1  slice carry-out, combinational
out_valid  output  1  result word available
out_ready  input  1  downstream accepts the result
out_result  output  WIDTH  assembled result
out_cout  output  1  carry-out of bit WIDTH-1
busy  output  1  high in the RUN or DONE state

Behaviour:
- FSM has three states: IDLE, RUN and DONE. Reset state is IDLE.
- On reset, all registered outputs are 0: out_valid=0, out_result=0, out_cout=0, busy=0. in_ready=1.
- In IDLE, all slice_* outputs are 0.
- IDLE:
  - in_ready=1.
  - When in_valid is high at a clock edge, the block latches op1, op2, mode, opsel and cin, clears bit counter cnt and the result shift register, and moves to RUN.
- RUN:
  - in_ready=0.
  - slice_op1 = op1_sh[0], slice_op2 = op2_sh[0], slice_cin = carry register. slice_mode and slice_opsel drive the latched values.
  - At each edge: res_sh <= {slice_result, res_sh[WIDTH-1:1]}, carry <= slice_cout, op1_sh and op2_sh shift right by one, cnt <= cnt+1.
  - At the edge where cnt == WIDTH-1, the block captures the final bit, loads out_result from the completed shift value, sets out_cout = slice_cout, sets out_valid=1 and moves to DONE.
- DONE:
  - out_valid=1. out_result and out_cout are held stable. in_ready=0.
  - On an edge with out_ready=1, out_valid is cleared and the FSM moves to IDLE.
  - out_result keeps its last value after the handshake; it is only valid while out_valid=1.
- Latency: accept edge T, then WIDTH RUN cycles. out_valid is high in the cycle after edge T+WIDTH. A new operation can be accepted no earlier than the edge after the output handshake, so throughput is one operation per WIDTH+2 cycles with out_ready tied high.
- cnt width is clog2(WIDTH), or 1 bit if WIDTH=1. cnt never wraps during RUN.
- The carry is chained in both arithmetic and logic modes. out_cout always reports the final slice_cout; interpretation belongs to the consumer.
- in_valid while busy is ignored, and no input state is changed. Upstream must hold its inputs until in_ready.
- rst asserted in any state, including mid-RUN or in DONE with out_ready low, returns the block to IDLE at that edge. The partial result is discarded and out_valid=0 in the next cycle.
- rst has priority over all handshakes at the same edge.

Test Plan:
The bench slice model is a full adder: result = a^b^cin, cout = majority(a,b,cin). WIDTH=8 unless stated otherwise.
1. in_op1=8'h5A, in_op2=8'h33, in_cin=0, accepted at edge T -> out_valid first high after edge T+8; out_result=8'h8D, out_cout=0; slice_op1 sequence (LSB first) 0,1,0,1,1,0,1,0.
2. in_op1=8'hFF, in_op2=8'h01, in_cin=0 -> out_result=8'h00, out_cout=1. Then in_op1=8'h00, in_op2=8'hFF, in_cin=1 -> out_result=8'h00, out_cout=1.
3. out_ready held low for 5 cycles in DONE -> out_valid, out_result and out_cout stable; in_ready=0; an in_valid pulse is ignored; the FSM returns to IDLE only at the edge where out_ready=1.
4. rst pulsed for one cycle when cnt=3 -> next cycle IDLE with in_ready=1, out_valid=0, busy=0. A following 8'h10+8'h20 operation gives 8'h30 with correct timing.
5. Back-to-back operations with out_ready tied high -> each accepted exactly WIDTH+2 cycles apart, and in_ready low for the whole interval.
6. WIDTH=1: 1+1 with in_cin=1 -> out_result=1, out_cout=1, out_valid high one cycle after the RUN edge.
